// File: rtl/mem_seq.sv
// mem_seq: asynchronous-SRAM access sequencer behind the Wishbone slave memory port.
// Drives CE/OE/WE timing with programmable read/write wait states and an
// external wait input, returns read data and a one-cycle acknowledge.
// Optional build macro MEM_SEQ_WDOG_EN adds an ACCESS watchdog that aborts a
// stuck access and flags it on err_o.
module mem_seq #(
   parameter int WAIT_RD = 2,
   parameter int WAIT_WR = 1,
   parameter int TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [25:0] mem_adr_i,
   input  logic        mem_r_i,
   input  logic        mem_w_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   output logic        err_o,
   output logic [25:0] sram_adr_o,
   output logic [31:0] sram_dat_o,
   output logic        sram_dat_oe,
   input  logic [31:0] sram_dat_i,
   output logic        sram_ce_b,
   output logic        sram_oe_b,
   output logic        sram_we_b,
   input  logic        sram_wait_i
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD,
      DONE
   } state_t;

   state_t     state;
   logic       is_rd;
   logic [3:0] wcnt;

`ifdef MEM_SEQ_WDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            abort;
`else
   logic [31:0] unused_timeout;

   assign unused_timeout = 32'(TIMEOUT);
   assign err_o          = 1'b0;
`endif

   // Access sequencer: every output is set on the edge that enters the state it belongs to
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         is_rd       <= 1'b0;
         wcnt        <= '0;
         sram_ce_b   <= 1'b1;
         sram_oe_b   <= 1'b1;
         sram_we_b   <= 1'b1;
         sram_dat_oe <= 1'b0;
         ack_o       <= 1'b0;
         dat_o       <= '0;
         sram_adr_o  <= '0;
         sram_dat_o  <= '0;
`ifdef MEM_SEQ_WDOG_EN
         wd_cnt      <= '0;
         abort       <= 1'b0;
         err_o       <= 1'b0;
`endif
      end else begin
         ack_o <= 1'b0;
         case (state)
            IDLE: begin
               // Read has priority when both strobes are presented together.
               if (mem_r_i) begin
                  sram_adr_o <= mem_adr_i;
                  is_rd      <= 1'b1;
                  sram_ce_b  <= 1'b0;
                  state      <= SETUP;
               end else if (mem_w_i) begin
                  sram_adr_o  <= mem_adr_i;
                  sram_dat_o  <= dat_i;
                  is_rd       <= 1'b0;
                  sram_ce_b   <= 1'b0;
                  sram_dat_oe <= 1'b1;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               wcnt      <= is_rd ? 4'(WAIT_RD) : 4'(WAIT_WR);
               sram_oe_b <= ~is_rd;
               sram_we_b <= is_rd;
               state     <= ACCESS;
`ifdef MEM_SEQ_WDOG_EN
               wd_cnt    <= '0;
               abort     <= 1'b0;
`endif
            end
            ACCESS: begin
               if (wcnt != 4'd0) begin
                  wcnt <= wcnt - 4'd1;
               end
               // Exit needs the wait-state count exhausted and no external wait on the same edge.
               if ((wcnt == 4'd0) && !sram_wait_i) begin
                  sram_oe_b <= 1'b1;
                  sram_we_b <= 1'b1;
                  if (is_rd) begin
                     dat_o <= sram_dat_i;
                  end
                  state <= HOLD;
               end
`ifdef MEM_SEQ_WDOG_EN
               else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  sram_oe_b <= 1'b1;
                  sram_we_b <= 1'b1;
                  abort     <= 1'b1;
                  if (is_rd) begin
                     dat_o <= '0;
                  end
                  state <= HOLD;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
`endif
            end
            HOLD: begin
               // Write data stays on the pads through HOLD; released together with CE.
               sram_ce_b   <= 1'b1;
               sram_dat_oe <= 1'b0;
               ack_o       <= 1'b1;
`ifdef MEM_SEQ_WDOG_EN
               err_o       <= abort;
`endif
               state       <= DONE;
            end
            DONE: begin
               // A request still held during the acknowledge cycle is not sampled here.
`ifdef MEM_SEQ_WDOG_EN
               err_o <= 1'b0;
`endif
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: scoreboard bench for mem_seq with a 16-word SRAM model.
// Build with MEM_SEQ_WDOG_EN defined to include the watchdog scenario.
`timescale 1ns/1ps
module tb_mem_seq;

   localparam int WAIT_RD = 2;
   localparam int WAIT_WR = 1;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [25:0] mem_adr_i;
   logic        mem_r_i;
   logic        mem_w_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        err_o;
   logic [25:0] sram_adr_o;
   logic [31:0] sram_dat_o;
   logic        sram_dat_oe;
   logic [31:0] sram_dat_i;
   logic        sram_ce_b;
   logic        sram_oe_b;
   logic        sram_we_b;
   logic        sram_wait_i;

   mem_seq #(
      .WAIT_RD(WAIT_RD),
      .WAIT_WR(WAIT_WR),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .mem_adr_i  (mem_adr_i),
      .mem_r_i    (mem_r_i),
      .mem_w_i    (mem_w_i),
      .dat_i      (dat_i),
      .dat_o      (dat_o),
      .ack_o      (ack_o),
      .err_o      (err_o),
      .sram_adr_o (sram_adr_o),
      .sram_dat_o (sram_dat_o),
      .sram_dat_oe(sram_dat_oe),
      .sram_dat_i (sram_dat_i),
      .sram_ce_b  (sram_ce_b),
      .sram_oe_b  (sram_oe_b),
      .sram_we_b  (sram_we_b),
      .sram_wait_i(sram_wait_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: 16 words, written while WE and CE are low with pads driven
   logic [31:0] mem [16];
   logic        pre_en;
   logic [3:0]  pre_a;
   logic [31:0] pre_d;

   always @(posedge clk) begin
      if (pre_en) mem[pre_a] <= pre_d;
      else if (!sram_we_b && !sram_ce_b && sram_dat_oe) mem[sram_adr_o[3:0]] <= sram_dat_o;
   end

   assign sram_dat_i = sram_oe_b ? 32'h0BAD_F00D : mem[sram_adr_o[3:0]];

   typedef struct {
      int          lat;
      int          oe_w;
      int          we_w;
      int          doe_w;
      logic [31:0] dat;
      logic        err;
   } exp_t;

   typedef struct {
      int   lat;
      int   oe_w;
      int   we_w;
      int   doe_w;
      int   acks;
      int   tail_act;
      int   frz_bad;
      int   ack_cyc;
      logic err;
   } obs_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Drive one request, measure strobes until ack, drop the request on the ack edge.
   task automatic run_access(input logic rd, input logic wr, input logic [25:0] adr,
                             input logic [31:0] wdata, input int wait_edges, input int tail,
                             output obs_t o);
      o = '{default: 0};
      o.lat = -1;
      @(negedge clk);
      mem_r_i     = rd;
      mem_w_i     = wr;
      mem_adr_i   = adr;
      dat_i       = wdata;
      sram_wait_i = (wait_edges > 0);
      for (int k = 0; k < 300 && o.lat < 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         sram_wait_i = (k + 1 < wait_edges);
         if (k == 0) begin
            mem_adr_i = ~adr;
            dat_i     = ~wdata;
         end
         if (!sram_oe_b) o.oe_w++;
         if (!sram_we_b) o.we_w++;
         if (sram_dat_oe) o.doe_w++;
         if (!sram_ce_b && sram_adr_o !== adr) o.frz_bad++;
         if (sram_dat_oe && sram_dat_o !== wdata) o.frz_bad++;
         if (ack_o) begin
            o.lat     = k;
            o.acks++;
            o.err     = err_o;
            o.ack_cyc = cyc;
         end
      end
      @(posedge clk);
      #1;
      mem_r_i     = 1'b0;
      mem_w_i     = 1'b0;
      sram_wait_i = 1'b0;
      for (int t = 0; t < tail; t++) begin
         @(negedge clk);
         if (ack_o) o.acks++;
         if (!sram_ce_b) o.tail_act++;
      end
   endtask

   task automatic test_reset();
      int strobes;
      strobes = 0;
      rst_i   = 1'b0;
      mem_r_i = 1'b1;
      pre_en  = 1'b1;
      pre_a   = 4'h3;
      pre_d   = 32'hA5A5_1234;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pre_en = 1'b0;
         if (!sram_ce_b || !sram_oe_b || !sram_we_b || sram_dat_oe || ack_o) strobes++;
      end
      vectors++; if (strobes !== 0) begin miscompares++; $display("FAIL reset_strobes got %0d active cycles, want 0", strobes); end
      vectors++; if (sram_ce_b !== 1'b1) begin miscompares++; $display("FAIL reset_ce_b got %b want 1", sram_ce_b); end
      vectors++; if (sram_oe_b !== 1'b1) begin miscompares++; $display("FAIL reset_oe_b got %b want 1", sram_oe_b); end
      vectors++; if (sram_we_b !== 1'b1) begin miscompares++; $display("FAIL reset_we_b got %b want 1", sram_we_b); end
      vectors++; if (sram_dat_oe !== 1'b0) begin miscompares++; $display("FAIL reset_dat_oe got %b want 0", sram_dat_oe); end
      vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", ack_o); end
      vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_o); end
      vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_dat_o got %h want 0", dat_o); end
      vectors++; if (sram_adr_o !== 26'h0) begin miscompares++; $display("FAIL reset_sram_adr got %h want 0", sram_adr_o); end
      vectors++; if (sram_dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_sram_dat got %h want 0", sram_dat_o); end
      rst_i   = 1'b1;
      mem_r_i = 1'b0;
   endtask

   task automatic test_read();
      exp_t e;
      obs_t o;
      sb.push_back('{lat: 5, oe_w: 3, we_w: 0, doe_w: 0, dat: 32'hA5A5_1234, err: 1'b0});
      run_access(1'b1, 1'b0, 26'h0000123, 32'h0, 0, 3, o);
      e = sb.pop_front();
      vectors++; if (o.lat !== e.lat) begin miscompares++; $display("FAIL read_latency got %0d want %0d", o.lat, e.lat); end
      vectors++; if (o.oe_w !== e.oe_w) begin miscompares++; $display("FAIL read_oe_width got %0d want %0d", o.oe_w, e.oe_w); end
      vectors++; if (o.we_w !== e.we_w) begin miscompares++; $display("FAIL read_we_width got %0d want %0d", o.we_w, e.we_w); end
      vectors++; if (dat_o !== e.dat) begin miscompares++; $display("FAIL read_data got %h want %h", dat_o, e.dat); end
      vectors++; if (o.err !== e.err) begin miscompares++; $display("FAIL read_err got %b want %b", o.err, e.err); end
      vectors++; if (o.frz_bad !== 0) begin miscompares++; $display("FAIL read_adr_freeze got %0d bad cycles want 0", o.frz_bad); end
      vectors++; if (o.acks !== 1 || o.tail_act !== 0) begin miscompares++; $display("FAIL read_single_ack got acks=%0d tail=%0d want 1/0", o.acks, o.tail_act); end
   endtask

   task automatic test_write();
      exp_t e;
      obs_t o;
      sb.push_back('{lat: 4, oe_w: 0, we_w: 2, doe_w: 4, dat: 32'hA5A5_1234, err: 1'b0});
      run_access(1'b0, 1'b1, 26'h3FFFFFF, 32'hCAFE_0001, 0, 3, o);
      e = sb.pop_front();
      vectors++; if (o.lat !== e.lat) begin miscompares++; $display("FAIL write_latency got %0d want %0d", o.lat, e.lat); end
      vectors++; if (o.we_w !== e.we_w) begin miscompares++; $display("FAIL write_we_width got %0d want %0d", o.we_w, e.we_w); end
      vectors++; if (o.oe_w !== e.oe_w) begin miscompares++; $display("FAIL write_oe_width got %0d want %0d", o.oe_w, e.oe_w); end
      vectors++; if (o.doe_w !== e.doe_w) begin miscompares++; $display("FAIL write_dat_oe_width got %0d want %0d", o.doe_w, e.doe_w); end
      vectors++; if (dat_o !== e.dat) begin miscompares++; $display("FAIL write_dat_o_kept got %h want %h", dat_o, e.dat); end
      vectors++; if (o.frz_bad !== 0) begin miscompares++; $display("FAIL write_freeze got %0d bad cycles want 0", o.frz_bad); end
      vectors++; if (o.acks !== 1 || o.tail_act !== 0) begin miscompares++; $display("FAIL write_single_ack got acks=%0d tail=%0d want 1/0", o.acks, o.tail_act); end
   endtask

   task automatic test_wait_stretch();
      exp_t e;
      obs_t o;
      sb.push_back('{lat: 9, oe_w: 7, we_w: 0, doe_w: 0, dat: 32'hCAFE_0001, err: 1'b0});
      run_access(1'b1, 1'b0, 26'h3FFFFFF, 32'h0, 8, 2, o);
      e = sb.pop_front();
      vectors++; if (o.lat !== e.lat) begin miscompares++; $display("FAIL stretch_latency got %0d want %0d", o.lat, e.lat); end
      vectors++; if (o.oe_w !== e.oe_w) begin miscompares++; $display("FAIL stretch_oe_width got %0d want %0d", o.oe_w, e.oe_w); end
      vectors++; if (dat_o !== e.dat) begin miscompares++; $display("FAIL stretch_data got %h want %h", dat_o, e.dat); end
      vectors++; if (o.acks !== 1) begin miscompares++; $display("FAIL stretch_acks got %0d want 1", o.acks); end
   endtask

   task automatic test_collision();
      exp_t e;
      obs_t o;
      sb.push_back('{lat: 5, oe_w: 3, we_w: 0, doe_w: 0, dat: 32'hA5A5_1234, err: 1'b0});
      run_access(1'b1, 1'b1, 26'h0000123, 32'h1111_2222, 0, 4, o);
      e = sb.pop_front();
      vectors++; if (o.we_w !== e.we_w || o.doe_w !== e.doe_w) begin miscompares++; $display("FAIL collision_no_write got we=%0d doe=%0d want 0/0", o.we_w, o.doe_w); end
      vectors++; if (o.oe_w !== e.oe_w) begin miscompares++; $display("FAIL collision_oe_width got %0d want %0d", o.oe_w, e.oe_w); end
      vectors++; if (dat_o !== e.dat) begin miscompares++; $display("FAIL collision_data got %h want %h", dat_o, e.dat); end
      vectors++; if (o.acks !== 1 || o.tail_act !== 0) begin miscompares++; $display("FAIL collision_single_ack got acks=%0d tail=%0d want 1/0", o.acks, o.tail_act); end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      obs_t        o;
      logic [31:0] d [4];
      int          prev;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         d[i] = $urandom;
         sb.push_back('{lat: 4, oe_w: 0, we_w: 2, doe_w: 4, dat: 32'h0, err: 1'b0});
         run_access(1'b0, 1'b1, 26'(i + 4), d[i], 0, 0, o);
         e = sb.pop_front();
         vectors++; if (o.lat !== e.lat || o.we_w !== e.we_w) begin miscompares++; $display("FAIL b2b_write%0d got lat=%0d we=%0d want %0d/%0d", i, o.lat, o.we_w, e.lat, e.we_w); end
         if (i > 0) begin
            vectors++; if (o.ack_cyc - prev !== 6) begin miscompares++; $display("FAIL b2b_write_spacing%0d got %0d want 6", i, o.ack_cyc - prev); end
         end
         prev = o.ack_cyc;
      end
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{lat: 5, oe_w: 3, we_w: 0, doe_w: 0, dat: d[i], err: 1'b0});
         run_access(1'b1, 1'b0, 26'(i + 4), 32'h0, 0, 0, o);
         e = sb.pop_front();
         vectors++; if (o.lat !== e.lat || dat_o !== e.dat) begin miscompares++; $display("FAIL b2b_read%0d got lat=%0d dat=%h want %0d/%h", i, o.lat, dat_o, e.lat, e.dat); end
         if (i > 0) begin
            vectors++; if (o.ack_cyc - prev !== 7) begin miscompares++; $display("FAIL b2b_read_spacing%0d got %0d want 7", i, o.ack_cyc - prev); end
         end
         prev = o.ack_cyc;
      end
   endtask

   task automatic test_abort();
      logic oe_mid;
      int   acks;
      acks = 0;
      @(negedge clk);
      mem_r_i     = 1'b1;
      mem_adr_i   = 26'h0000123;
      sram_wait_i = 1'b1;
      repeat (3) @(negedge clk);
      oe_mid = sram_oe_b;
      rst_i  = 1'b0;
      @(negedge clk);
      vectors++; if (oe_mid !== 1'b0) begin miscompares++; $display("FAIL abort_in_access got oe_b=%b want 0", oe_mid); end
      vectors++; if (sram_ce_b !== 1'b1 || sram_oe_b !== 1'b1 || sram_we_b !== 1'b1) begin miscompares++; $display("FAIL abort_strobes got ce=%b oe=%b we=%b want 111", sram_ce_b, sram_oe_b, sram_we_b); end
      vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL abort_dat_o got %h want 0", dat_o); end
      rst_i       = 1'b1;
      mem_r_i     = 1'b0;
      sram_wait_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack_o || !sram_ce_b) acks++;
      end
      vectors++; if (acks !== 0) begin miscompares++; $display("FAIL abort_no_ack got %0d active cycles want 0", acks); end
   endtask

`ifdef MEM_SEQ_WDOG_EN
   task automatic test_watchdog();
      exp_t e;
      obs_t o;
      sb.push_back('{lat: 5, oe_w: 3, we_w: 0, doe_w: 0, dat: 32'hA5A5_1234, err: 1'b0});
      run_access(1'b1, 1'b0, 26'h0000003, 32'h0, 0, 0, o);
      e = sb.pop_front();
      vectors++; if (dat_o !== e.dat || o.err !== e.err) begin miscompares++; $display("FAIL wdog_preread got dat=%h err=%b want %h/%b", dat_o, o.err, e.dat, e.err); end
      sb.push_back('{lat: 10, oe_w: 8, we_w: 0, doe_w: 0, dat: 32'h0, err: 1'b1});
      run_access(1'b1, 1'b0, 26'h0000003, 32'h0, 1000, 2, o);
      e = sb.pop_front();
      vectors++; if (o.lat !== e.lat) begin miscompares++; $display("FAIL wdog_latency got %0d want %0d", o.lat, e.lat); end
      vectors++; if (o.oe_w !== e.oe_w) begin miscompares++; $display("FAIL wdog_oe_width got %0d want %0d", o.oe_w, e.oe_w); end
      vectors++; if (o.err !== e.err) begin miscompares++; $display("FAIL wdog_err got %b want %b", o.err, e.err); end
      vectors++; if (dat_o !== e.dat) begin miscompares++; $display("FAIL wdog_dat_o got %h want %h", dat_o, e.dat); end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL global_timeout simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_i       = 1'b0;
      mem_adr_i   = 26'h0000123;
      mem_r_i     = 1'b0;
      mem_w_i     = 1'b0;
      dat_i       = 32'h0;
      sram_wait_i = 1'b0;
      pre_en      = 1'b0;
      pre_a       = 4'h0;
      pre_d       = 32'h0;
      test_reset();
      test_read();
      test_write();
      test_wait_stretch();
      test_collision();
      test_back_to_back();
      test_abort();
`ifdef MEM_SEQ_WDOG_EN
      test_watchdog();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
